fnd_capture: RTL and testbench

- Monitor that sits on the multiplexed 4-digit 7-segment bus (fndCom/fndFont) and reconstructs the displayed 14-bit decimal value.
- Samples each digit position while its common line is active and inverse-decodes the segment font to BCD.
- Presents the assembled number once all four positions have been captured.
- Used for loopback self-check of the display path and for reading back a displayed value over the UART test path.

---
 rtl/fnd_capture_if.sv | 14 +
 rtl/fnd_capture.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fnd_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fnd_capture_if.sv
// Multiplexed 4-digit 7-segment display bus (commons + segment font).
// Latency: n/a (wires only).
// Backpressure: none; the bus is a free-running scan with no flow control.
//
// fndCom  : digit commons, active-low one-hot (1110=ones .. 0111=thousands)
// fndFont : segment lines, active-low; bit7 = decimal point, bits[6:0] = g..a
// master  : the display driver; slave : a monitor such as fnd_capture
interface fnd_capture_if;
    logic [3:0] fndCom;
    logic [7:0] fndFont;

    modport master (output fndCom, output fndFont);
    modport slave  (input  fndCom, input  fndFont);
endinterface

// File: rtl/fnd_capture.sv
// Monitor that reconstructs the 4-digit decimal value shown on a multiplexed 7-segment bus.
// Latency: 2 sync cycles + SETTLE_CYCLES stable cycles per digit; number/number_valid one cycle after the frame-completing sample.
// Backpressure: none; a passive observer, pulses are never held or retried.
//
// Ports: clk, reset (async, active-high); bus (fnd_capture_if.slave: fndCom, fndFont);
//        number[13:0] last good value, number_valid / frame_err one-cycle pulses,
//        stale level (no digit sampled for TIMEOUT_CYCLES).
// Optional: define FND_DP_EN to add dp[3:0] (decimal point per digit, updated with number).
module fnd_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 400_000
) (
    input  logic          clk,
    input  logic          reset,
    fnd_capture_if.slave  bus,
    output logic [13:0]   number,
    output logic          number_valid,
    output logic          frame_err,
    output logic          stale
`ifdef FND_DP_EN
    ,
    output logic [3:0]    dp
`endif
);

`ifdef FND_DP_EN
    localparam int FW = 8;
`else
    // Decimal point is ignored entirely, including for settle stability.
    localparam int FW = 7;
    logic unused_dp_bit;
    assign unused_dp_bit = bus.fndFont[7];
`endif
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {WAIT_COM, SETTLE, HOLD} state_t;

    // Returns {invalid, digit}; hex glyphs decode to A..F so they are flagged at assembly.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [3:0]      com_s1_q, com_s1_d, com_s2_q, com_s2_d;
    logic [FW-1:0]   font_s1_q, font_s1_d, font_s2_q, font_s2_d;
    state_t          state_q, state_d;
    logic [3:0]      lat_com_q, lat_com_d;
    logic [FW-1:0]   lat_font_q, lat_font_d;
    logic [1:0]      pos_q, pos_d;
    logic [SW-1:0]   set_cnt_q, set_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      inv_q, inv_d;
    logic [3:0][3:0] digit_q, digit_d;
    logic [13:0]     number_q, number_d;
    logic            number_valid_q, number_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            stale_q, stale_d;
`ifdef FND_DP_EN
    logic [3:0]      dps_q, dps_d;
    logic [3:0]      dp_q, dp_d;
`endif

    // Commons are legal only with exactly one active (zero) line.
    logic       com_legal;
    logic [1:0] com_pos;
    always_comb begin
        com_legal = 1'b1;
        com_pos   = 2'd0;
        case (com_s2_q)
            4'b1110: com_pos = 2'd0;
            4'b1101: com_pos = 2'd1;
            4'b1011: com_pos = 2'd2;
            4'b0111: com_pos = 2'd3;
            default: com_legal = 1'b0;
        endcase
    end

    logic       sample;
    logic [4:0] dec;
    logic [3:0] mask_nxt;
    logic       frame_ok;

    always_comb begin
        com_s1_d       = bus.fndCom;
        com_s2_d       = com_s1_q;
        font_s1_d      = bus.fndFont[FW-1:0];
        font_s2_d      = font_s1_q;
        state_d        = state_q;
        lat_com_d      = lat_com_q;
        lat_font_d     = lat_font_q;
        pos_d          = pos_q;
        set_cnt_d      = set_cnt_q;
        to_cnt_d       = to_cnt_q;
        mask_d         = mask_q;
        inv_d          = inv_q;
        digit_d        = digit_q;
        number_d       = number_q;
        number_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        stale_d        = stale_q;
`ifdef FND_DP_EN
        dps_d          = dps_q;
        dp_d           = dp_q;
`endif
        sample         = 1'b0;
        frame_ok       = 1'b1;
        dec            = seg_decode(lat_font_q[6:0]);
        mask_nxt       = mask_q | (4'b0001 << pos_q);

        case (state_q)
            WAIT_COM: begin
                if (com_legal) begin
                    lat_com_d  = com_s2_q;
                    lat_font_d = font_s2_q;
                    pos_d      = com_pos;
                    set_cnt_d  = '0;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (!com_legal) begin
                    state_d = WAIT_COM;
                end else if (com_s2_q != lat_com_q || font_s2_q != lat_font_q) begin
                    lat_com_d  = com_s2_q;
                    lat_font_d = font_s2_q;
                    pos_d      = com_pos;
                    set_cnt_d  = '0;
                end else if (set_cnt_q == SW'(SETTLE_CYCLES - 2)) begin
                    // Latch cycle plus SETTLE_CYCLES-1 matching cycles: stable long enough.
                    sample  = 1'b1;
                    state_d = HOLD;
                end else begin
                    set_cnt_d = set_cnt_q + SW'(1);
                end
            end
            HOLD: begin
                // Only a commons change ends the dwell; font glitches here are ignored.
                if (com_s2_q != lat_com_q) begin
                    if (com_legal) begin
                        lat_com_d  = com_s2_q;
                        lat_font_d = font_s2_q;
                        pos_d      = com_pos;
                        set_cnt_d  = '0;
                        state_d    = SETTLE;
                    end else begin
                        state_d = WAIT_COM;
                    end
                end
            end
            default: state_d = WAIT_COM;
        endcase

        if (sample) begin
            to_cnt_d        = '0;
            stale_d         = 1'b0;
            digit_d[pos_q]  = dec[3:0];
            inv_d[pos_q]    = dec[4];
`ifdef FND_DP_EN
            dps_d[pos_q]    = ~lat_font_q[7];
`endif
            if (mask_nxt == 4'hF) begin
                for (int i = 0; i < 4; i++) begin
                    if (inv_d[i] || digit_d[i] > 4'd9) frame_ok = 1'b0;
                end
                if (frame_ok) begin
                    number_d = 14'(digit_d[3]) * 14'd1000 + 14'(digit_d[2]) * 14'd100
                             + 14'(digit_d[1]) * 14'd10   + 14'(digit_d[0]);
                    number_valid_d = 1'b1;
`ifdef FND_DP_EN
                    dp_d = dps_d;
`endif
                end else begin
                    frame_err_d = 1'b1;
                end
                mask_d = 4'h0;
                inv_d  = 4'h0;
            end else begin
                mask_d = mask_nxt;
            end
        end else begin
            if (to_cnt_q != TW'(TIMEOUT_CYCLES - 1)) to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_d == TW'(TIMEOUT_CYCLES - 1)) begin
                // Stale bus: drop whatever partial frame was being collected.
                stale_d = 1'b1;
                mask_d  = 4'h0;
                inv_d   = 4'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            com_s1_q       <= 4'hF;
            com_s2_q       <= 4'hF;
            font_s1_q      <= '1;
            font_s2_q      <= '1;
            state_q        <= WAIT_COM;
            lat_com_q      <= 4'hF;
            lat_font_q     <= '1;
            pos_q          <= 2'd0;
            set_cnt_q      <= '0;
            to_cnt_q       <= '0;
            mask_q         <= 4'h0;
            inv_q          <= 4'h0;
            digit_q        <= '0;
            number_q       <= 14'd0;
            number_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            stale_q        <= 1'b0;
`ifdef FND_DP_EN
            dps_q          <= 4'h0;
            dp_q           <= 4'h0;
`endif
        end else begin
            com_s1_q       <= com_s1_d;
            com_s2_q       <= com_s2_d;
            font_s1_q      <= font_s1_d;
            font_s2_q      <= font_s2_d;
            state_q        <= state_d;
            lat_com_q      <= lat_com_d;
            lat_font_q     <= lat_font_d;
            pos_q          <= pos_d;
            set_cnt_q      <= set_cnt_d;
            to_cnt_q       <= to_cnt_d;
            mask_q         <= mask_d;
            inv_q          <= inv_d;
            digit_q        <= digit_d;
            number_q       <= number_d;
            number_valid_q <= number_valid_d;
            frame_err_q    <= frame_err_d;
            stale_q        <= stale_d;
`ifdef FND_DP_EN
            dps_q          <= dps_d;
            dp_q           <= dp_d;
`endif
        end
    end

    assign number       = number_q;
    assign number_valid = number_valid_q;
    assign frame_err    = frame_err_q;
    assign stale        = stale_q;
`ifdef FND_DP_EN
    assign dp           = dp_q;
`endif

endmodule

// File: tb/tb_fnd_capture.sv
// Directed bench for fnd_capture: scans digit patterns onto the bus and checks the reconstructed value.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_fnd_capture;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] number;
    logic        number_valid;
    logic        frame_err;
    logic        stale;
`ifdef FND_DP_EN
    logic [3:0]  dp;
`endif

    fnd_capture_if bus ();

    fnd_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .number       (number),
        .number_valid (number_valid),
        .frame_err    (frame_err),
        .stale        (stale)
`ifdef FND_DP_EN
        ,
        .dp           (dp)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int nv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (number_valid) nv_cnt++;
        if (frame_err) fe_cnt++;
        if (number_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One digit dwell: drive commons/font on the falling edge and hold for the dwell.
    task automatic show(input logic [3:0] com, input logic [7:0] font, input int dwell);
        @(negedge clk);
        bus.fndCom  = com;
        bus.fndFont = font;
        repeat (dwell - 1) @(negedge clk);
    endtask

    localparam logic [3:0] C1 = 4'b1110, C10 = 4'b1101, C100 = 4'b1011, C1000 = 4'b0111;

    int nv0, fe0;

    initial begin
        bus.fndCom  = 4'hF;
        bus.fndFont = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_number", 32'(number), 0);
        check("rst_valid", 32'(number_valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_stale", 32'(stale), 0);
`ifdef FND_DP_EN
        check("rst_dp", 32'(dp), 0);
`endif
        reset = 1'b0;

        // 1234, twice: one pulse per full scan
        nv0 = nv_cnt; fe0 = fe_cnt;
        show(C1, 8'h99, 100); show(C10, 8'hB0, 100); show(C100, 8'hA4, 100);
        check("1234_no_early_valid", 32'(nv_cnt - nv0), 0);
        show(C1000, 8'hF9, 100);
        check("1234_valid", 32'(nv_cnt - nv0), 1);
        check("1234_number", 32'(number), 1234);
        show(C1, 8'h99, 100); show(C10, 8'hB0, 100); show(C100, 8'hA4, 100); show(C1000, 8'hF9, 100);
        check("1234_second_scan_valid", 32'(nv_cnt - nv0), 2);
        check("1234_no_ferr", 32'(fe_cnt - fe0), 0);

        // 0000 then 9999
        nv0 = nv_cnt;
        for (int i = 0; i < 4; i++) show(4'hF ^ (4'b0001 << i), 8'hC0, 100);
        check("0000_valid", 32'(nv_cnt - nv0), 1);
        check("0000_number", 32'(number), 0);
        for (int i = 0; i < 3; i++) show(4'hF ^ (4'b0001 << i), 8'h90, 100);
        check("9999_no_early_valid", 32'(nv_cnt - nv0), 1);
        show(C1000, 8'h90, 100);
        check("9999_valid", 32'(nv_cnt - nv0), 2);
        check("9999_number", 32'(number), 9999);

        // hex glyph A on the hundreds digit
        nv0 = nv_cnt; fe0 = fe_cnt;
        show(C1, 8'h99, 100); show(C10, 8'hB0, 100); show(C100, 8'h88, 100); show(C1000, 8'hF9, 100);
        check("hex_ferr", 32'(fe_cnt - fe0), 1);
        check("hex_no_valid", 32'(nv_cnt - nv0), 0);
        check("hex_number_held", 32'(number), 9999);

        // tens digit never settles, captured only on the next full dwell
        nv0 = nv_cnt;
        show(C1, 8'h92, 100);
        for (int i = 0; i < SETTLE - 2; i++) begin
            @(negedge clk);
            bus.fndCom  = C10;
            bus.fndFont = i[0] ? 8'hB0 : 8'h82;
        end
        show(C100, 8'hF8, 100); show(C1000, 8'h80, 100);
        check("short_dwell_no_valid", 32'(nv_cnt - nv0), 0);
        show(C10, 8'h82, 100);
        check("short_dwell_late_valid", 32'(nv_cnt - nv0), 1);
        check("short_dwell_number", 32'(number), 8765);

        // partial frame, then timeout, then 5678
        nv0 = nv_cnt;
        show(C10, 8'hF9, 100); show(C100, 8'hF9, 100); show(C1000, 8'hF9, 100);
        check("pre_timeout_stale", 32'(stale), 0);
        show(4'hF, 8'hFF, 500);
        check("mid_timeout_stale", 32'(stale), 0);
        show(4'hF, 8'hFF, TIMEOUT + 10 - 500);
        check("timeout_stale", 32'(stale), 1);
        show(C1, 8'h80, 100);
        check("stale_cleared", 32'(stale), 0);
        check("timeout_mask_cleared", 32'(nv_cnt - nv0), 0);
        show(C10, 8'hF8, 100); show(C100, 8'h82, 100); show(C1000, 8'h92, 100);
        check("5678_valid", 32'(nv_cnt - nv0), 1);
        check("5678_number", 32'(number), 5678);

        // reset after 3 captured digits, then a fresh 4321 frame
        show(C1, 8'hF9, 100); show(C10, 8'hA4, 100); show(C100, 8'hB0, 100);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_number", 32'(number), 0);
        check("midreset_stale", 32'(stale), 0);
        reset = 1'b0;
        nv0 = nv_cnt;
        show(C1000, 8'h99, 100); show(C1, 8'hF9, 100); show(C10, 8'hA4, 100);
        check("4321_no_early_valid", 32'(nv_cnt - nv0), 0);
        show(C100, 8'h30, 100);
        check("4321_valid", 32'(nv_cnt - nv0), 1);
        check("4321_number", 32'(number), 4321);
`ifdef FND_DP_EN
        check("4321_dp", 32'(dp), 32'b0100);
`endif
        check("valid_ferr_exclusive", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
